// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, reset fetch address and NOP word.
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2,
        FETCH_HOLD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0030;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

endpackage

// File: rtl/pc_reg.sv
// Fetch program counter: loadable register that resets to the boot address.
module pc_reg #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_PC;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding memory request, hands one
// instruction at a time to decode and honours redirect and stall.
//
//   state | meaning
//   IDLE  | post-reset, no request issued yet
//   REQ   | request for fetch PC presented (suppressed while a squashed response is owed)
//   WAIT  | request accepted, waiting for the response
//   HOLD  | captured instruction presented to decode until stall drops
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] next_pc,
    input  logic             redirect,
    input  logic             stall,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ready,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             if_valid,
    output logic [WIDTH-1:0] if_pc,
    output logic [WIDTH-1:0] if_instr
);

    fetch_state_t     state, state_nxt;
    logic             squash, squash_nxt;
    logic             valid_nxt;
    logic [WIDTH-1:0] ifpc_nxt, instr_nxt;
    logic [WIDTH-1:0] pc, pc_d;
    logic             pc_load;

    pc_reg #(
        .WIDTH    (WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .load  (pc_load),
        .d     (pc_d),
        .q     (pc)
    );

    assign pc_plus4  = pc + WIDTH'(4);
    assign imem_addr = pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FETCH_IDLE;
            squash   <= 1'b0;
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_instr <= '0;
        end else begin
            state    <= state_nxt;
            squash   <= squash_nxt;
            if_valid <= valid_nxt;
            if_pc    <= ifpc_nxt;
            if_instr <= instr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        squash_nxt = squash;
        valid_nxt  = if_valid;
        ifpc_nxt   = if_pc;
        instr_nxt  = if_instr;
        pc_load    = 1'b0;
        pc_d       = pc_plus4;
        imem_req   = 1'b0;

        case (state)
            FETCH_IDLE: begin
                state_nxt = FETCH_REQ;
            end
            FETCH_REQ: begin
                // A squashed response is still owed: hold off the next request until it lands.
                imem_req = !squash;
                if (squash) begin
                    if (imem_rvalid) squash_nxt = 1'b0;
                end else if (imem_ready) begin
                    state_nxt = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imem_rvalid) begin
                    valid_nxt = 1'b1;
                    ifpc_nxt  = pc;
                    instr_nxt = imem_rdata;
                    pc_load   = 1'b1;
                    state_nxt = FETCH_HOLD;
                end
            end
            FETCH_HOLD: begin
                if (!stall) begin
                    valid_nxt = 1'b0;
                    state_nxt = FETCH_REQ;
                end
            end
            default: state_nxt = FETCH_IDLE;
        endcase

        if (redirect) begin
            state_nxt  = FETCH_REQ;
            valid_nxt  = 1'b0;
            ifpc_nxt   = if_pc;
            instr_nxt  = if_instr;
            pc_load    = 1'b1;
            pc_d       = next_pc;
            // Any request the memory still owes a response for must be dropped on arrival.
            squash_nxt = ((state == FETCH_WAIT) && !imem_rvalid) ||
                         ((state == FETCH_REQ) && squash && !imem_rvalid) ||
                         ((state == FETCH_REQ) && !squash && imem_ready);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then randomized traffic
// compared against a transaction-level model of the fetch stage.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] next_pc;
    logic        redirect;
    logic        stall;
    logic [31:0] pc_plus4;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    int n_chk  = 0;
    int n_pass = 0;

    // model: fetch PC, started flag, outstanding request, drop-on-arrival, presented instruction
    logic [31:0] m_pc;
    bit          m_started;
    bit          m_out;
    bit          m_drop;
    bit          m_show;
    logic [31:0] m_ipc;
    logic [31:0] m_ins;

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .next_pc     (next_pc),
        .redirect    (redirect),
        .stall       (stall),
        .pc_plus4    (pc_plus4),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic bit m_req();
        return m_started && !m_out && !m_show;
    endfunction

    task automatic model_update();
        bit accepted;
        if (reset) begin
            m_pc = 32'h0040_0030; m_started = 0; m_out = 0; m_drop = 0;
            m_show = 0; m_ipc = '0; m_ins = '0;
            return;
        end
        accepted = m_req() && imem_ready;
        if (redirect) begin
            m_pc      = next_pc;
            m_show    = 0;
            m_started = 1;
            m_out     = (m_out && !imem_rvalid) || accepted;
            m_drop    = m_out;
        end else if (!m_started) begin
            m_started = 1;
        end else if (m_out) begin
            if (imem_rvalid) begin
                m_out = 0;
                if (m_drop) m_drop = 0;
                else begin
                    m_show = 1; m_ipc = m_pc; m_ins = imem_rdata; m_pc = m_pc + 32'd4;
                end
            end
        end else if (m_show) begin
            if (!stall) m_show = 0;
        end else if (imem_ready) begin
            m_out  = 1;
            m_drop = 0;
        end
    endtask

    task automatic model_check();
        chk("imem_req", {31'd0, imem_req}, {31'd0, m_req()});
        if (m_req()) chk("imem_addr", imem_addr, m_pc);
        chk("if_valid", {31'd0, if_valid}, {31'd0, m_show});
        chk("if_pc", if_pc, m_ipc);
        chk("if_instr", if_instr, m_ins);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        model_check();
    endtask

    initial begin
        reset = 1'b1; next_pc = '0; redirect = 0; stall = 0;
        imem_ready = 0; imem_rvalid = 0; imem_rdata = '0;
        step(); step();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);

        // basic fetch
        reset = 1'b0; imem_ready = 1;
        step();
        chk("first_addr", imem_addr, 32'h0040_0030);
        chk("first_pc4", pc_plus4, 32'h0040_0034);
        step();
        imem_rvalid = 1; imem_rdata = 32'h2008_0005;
        step();
        imem_rvalid = 0;
        chk("first_vld", {31'd0, if_valid}, 32'd1);
        chk("first_ifpc", if_pc, 32'h0040_0030);
        chk("first_ins", if_instr, 32'h2008_0005);

        // stall holds the presented instruction
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_vld", {31'd0, if_valid}, 32'd1);
            chk("stall_ifpc", if_pc, 32'h0040_0030);
            chk("stall_ins", if_instr, 32'h2008_0005);
            chk("stall_noreq", {31'd0, imem_req}, 32'd0);
        end
        stall = 0; imem_ready = 0;
        step();
        chk("post_stall_vld", {31'd0, if_valid}, 32'd0);

        // memory not ready: request held stable
        for (int i = 0; i < 4; i++) begin
            step();
            chk("nrdy_req", {31'd0, imem_req}, 32'd1);
            chk("nrdy_addr", imem_addr, 32'h0040_0034);
        end
        imem_ready = 1;
        step();

        // redirect while waiting: old response dropped
        redirect = 1; next_pc = 32'h0040_0100;
        step();
        redirect = 0;
        chk("squash_noreq", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 0;
        chk("squash_vld", {31'd0, if_valid}, 32'd0);
        chk("redir_addr", imem_addr, 32'h0040_0100);
        step();
        imem_rvalid = 1; imem_rdata = 32'h1111_1111;
        step();
        imem_rvalid = 0;
        chk("redir_ifpc", if_pc, 32'h0040_0100);
        chk("redir_ins", if_instr, 32'h1111_1111);

        // wrap at top of address space
        redirect = 1; next_pc = 32'hFFFF_FFFC;
        step();
        redirect = 0;
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        step();
        imem_rvalid = 1; imem_rdata = 32'h0000_0013;
        step();
        imem_rvalid = 0;
        chk("wrap_ifpc", if_pc, 32'hFFFF_FFFC);
        step();
        chk("wrap_addr1", imem_addr, 32'h0000_0000);

        // reset in WAIT
        step();
        reset = 1;
        #1;
        chk("rst_async_vld", {31'd0, if_valid}, 32'd0);
        chk("rst_async_req", {31'd0, imem_req}, 32'd0);
        step();
        reset = 0; imem_rvalid = 1; imem_rdata = 32'hBAD0_BAD0; imem_ready = 0;
        step();
        step();
        imem_rvalid = 0;
        chk("refetch_addr", imem_addr, 32'h0040_0030);
        chk("late_vld", {31'd0, if_valid}, 32'd0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            reset       = ($urandom_range(0, 299) == 0);
            imem_ready  = ($urandom_range(0, 9) < 7);
            imem_rvalid = ($urandom_range(0, 9) < 4);
            imem_rdata  = $urandom();
            stall       = ($urandom_range(0, 9) < 3);
            redirect    = ($urandom_range(0, 19) == 0);
            next_pc     = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
